fetch_issue_ctrl: RTL and testbench

FETCH_ISSUE_CTRL -- requirements
Module: fetch_issue_ctrl

---
 rtl/fetch_issue_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_issue_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_ctrl.sv
// Fetch-to-decode instruction queue: compacts NOP-free pairs into a circular FIFO,
// offers up to two instructions per cycle to decode, and handles branch flush/drain.
module fetch_issue_ctrl #(
  parameter int DEPTH    = 8,
  parameter int STALL_TH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              instr1,
  input  logic [15:0]              instr2,
  input  logic                     flush,
  input  logic                     issue_ready,
  output logic                     fetch_stall,
  output logic [15:0]              issue_instr1,
  output logic [15:0]              issue_instr2,
  output logic                     issue_valid1,
  output logic                     issue_valid2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || STALL_TH < 1 || STALL_TH > DEPTH - 4) begin : g_bad_params
    $error("fetch_issue_ctrl: DEPTH must be a power of two >= 4 and STALL_TH in 1..DEPTH-4");
  end

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] head, tail;

  logic [15:0]   head_entry, next_entry;
  logic [2:0]    head_rd;
  logic          hazard, run, accept, drop;
  logic [1:0]    deq_n, in_n, enq_n;
  logic [15:0]   first_instr, second_instr;
  logic [CW-1:0] free_slots;

  // Two-entry lookahead at the head for dual issue and the RAW check.
  assign head_entry = mem[head];
  assign next_entry = mem[head + AW'(1)];
  assign head_rd    = head_entry[11:9];
  assign hazard     = (head_rd != 3'd0) &&
                      (next_entry[8:6] == head_rd || next_entry[5:3] == head_rd);

  assign run    = (state == RUN);
  assign accept = run && !flush;

  assign issue_valid1 = accept && (count >= CW'(1));
  assign issue_valid2 = accept && (count >= CW'(2)) && !hazard;
  assign issue_instr1 = issue_valid1 ? head_entry : 16'h0000;
  assign issue_instr2 = issue_valid2 ? next_entry : 16'h0000;
  assign fetch_stall  = run && (count >= CW'(STALL_TH));

  // Issue valids already fold in flush and DRAIN, so deq_n is zero there.
  always_comb begin
    deq_n        = issue_ready ? ({1'b0, issue_valid1} + {1'b0, issue_valid2}) : 2'd0;
    first_instr  = instr1;
    second_instr = instr2;
    in_n         = 2'd0;
    if (instr1 != 16'h0000) begin
      in_n = (instr2 != 16'h0000) ? 2'd2 : 2'd1;
    end else if (instr2 != 16'h0000) begin
      first_instr = instr2;
      in_n        = 2'd1;
    end
    // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
    free_slots = CW'(DEPTH) - count + CW'(deq_n);
    drop       = accept && (CW'(in_n) > free_slots);
    enq_n      = 2'd0;
    if (accept) begin
      enq_n = (CW'(in_n) > free_slots) ? free_slots[1:0] : in_n;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   state_next = flush ? DRAIN : RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        head     <= head + AW'(deq_n);
        tail     <= tail + AW'(enq_n);
        count    <= count - CW'(deq_n) + CW'(enq_n);
        overflow <= overflow | drop;
      end
    end
  end

  // NOTE: storage has no reset; entries are only observable once written and counted.
  always_ff @(posedge clk) begin
    if (!reset && enq_n != 2'd0) begin
      mem[tail] <= first_instr;
      if (enq_n == 2'd2) mem[tail + AW'(1)] <= second_instr;
    end
  end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Scoreboard bench for fetch_issue_ctrl: a queue-based reference model predicts the
// combinational outputs each cycle; a negedge monitor compares them against the DUT.
module tb_fetch_issue_ctrl;

  localparam int DEPTH    = 8;
  localparam int STALL_TH = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   instr1 = 16'h0000, instr2 = 16'h0000;
  logic          flush = 1'b0, issue_ready = 1'b0;
  logic          fetch_stall, issue_valid1, issue_valid2, overflow;
  logic [15:0]   issue_instr1, issue_instr2;
  logic [CW-1:0] count;

  fetch_issue_ctrl #(.DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr1       (instr1),
    .instr2       (instr2),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .fetch_stall  (fetch_stall),
    .issue_instr1 (issue_instr1),
    .issue_instr2 (issue_instr2),
    .issue_valid1 (issue_valid1),
    .issue_valid2 (issue_valid2),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          v1, v2;
    logic [15:0]   i1, i2;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_q[$];
  bit          m_drain, m_ovf;
  int          n_cmp, n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest prediction.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("fetch_stall",  32'(fetch_stall),  32'(mon_e.stall));
      check("issue_valid1", 32'(issue_valid1), 32'(mon_e.v1));
      check("issue_valid2", 32'(issue_valid2), 32'(mon_e.v2));
      check("issue_instr1", 32'(issue_instr1), 32'(mon_e.i1));
      check("issue_instr2", 32'(issue_instr2), 32'(mon_e.i2));
      check("count",        32'(count),        32'(mon_e.cnt));
      check("overflow",     32'(overflow),     32'(mon_e.ovf));
    end
  end

  task automatic model_push(input logic [15:0] v);
    if (v == 16'h0000) return;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    else m_ovf = 1'b1;
  endtask

  // Drive one cycle, predict outputs from the model, then advance the model past the edge.
  task automatic cycle(input bit rst, input logic [15:0] a, input logic [15:0] b,
                       input bit fl, input bit rdy);
    exp_t ex;
    int   n;
    bit   run, hz;
    logic [2:0] rd;
    @(posedge clk);
    #1;
    reset = rst; instr1 = a; instr2 = b; flush = fl; issue_ready = rdy;
    n   = model_q.size();
    run = !m_drain;
    hz  = 1'b0;
    if (n >= 2) begin
      rd = model_q[0][11:9];
      hz = (rd != 3'd0) && (model_q[1][8:6] == rd || model_q[1][5:3] == rd);
    end
    ex.v1    = run && !fl && n >= 1;
    ex.v2    = run && !fl && n >= 2 && !hz;
    ex.i1    = ex.v1 ? model_q[0] : 16'h0000;
    ex.i2    = ex.v2 ? model_q[1] : 16'h0000;
    ex.stall = run && n >= STALL_TH;
    ex.cnt   = CW'(n);
    ex.ovf   = m_ovf;
    exp_q.push_back(ex);
    if (rst) begin
      model_q.delete(); m_drain = 1'b0; m_ovf = 1'b0;
    end else if (fl) begin
      model_q.delete(); m_drain = 1'b1;
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else begin
      if (rdy) repeat (int'(ex.v1) + int'(ex.v2)) void'(model_q.pop_front());
      model_push(a);
      model_push(b);
    end
  endtask

  function automatic logic [15:0] rnd_instr();
    if ($urandom_range(0, 3) == 0) return 16'h0000;
    return 16'($urandom_range(1, 16'hFFFF));
  endfunction

  logic [15:0] ra, rb;
  bit          rrst, rfl, rrdy;

  initial begin
    n_cmp = 0; n_err = 0;
    m_drain = 1'b0; m_ovf = 1'b0;
    @(posedge clk);
    // Reset state, then a hazarding pair held at the head.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h1234, 16'h2456, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Independent pair issues together.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h1A00, 16'h2048, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 1);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Lone younger instruction lands at the tail.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h0000, 16'h3000, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Fill past the stall threshold and then overflow; overflow clears only on reset.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 16'(16'h4100 + i), 16'(16'h5200 + i), 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 1);
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Flush with valid inputs, stale pair in DRAIN discarded, next pair accepted.
    cycle(0, 16'h6001, 16'h6002, 0, 0);
    cycle(0, 16'h6003, 16'h0000, 0, 0);
    cycle(0, 16'h7001, 16'h7002, 1, 1);
    cycle(0, 16'h7003, 16'h7004, 0, 1);
    cycle(0, 16'h7005, 16'h7006, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Flush while already draining, then reset mid-DRAIN and accept right after.
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    cycle(0, 16'h8001, 16'h8002, 1, 0);
    cycle(1, 16'h8003, 16'h8004, 0, 1);
    cycle(0, 16'h8005, 16'h8006, 0, 0);
    cycle(0, 16'h0000, 16'h0000, 0, 0);
    // Wrap-around: hazard-free stream (rd=0) through 3 x DEPTH cycles.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ra = 16'($urandom) & 16'hF1FF | 16'h1000;
      rb = 16'($urandom) & 16'hF1FF | 16'h2000;
      cycle(0, ra, rb, 0, 1);
    end
    cycle(0, 16'h0000, 16'h0000, 0, 1);
    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      ra   = rnd_instr();
      rb   = rnd_instr();
      rrst = ($urandom_range(0, 99) == 0);
      rfl  = ($urandom_range(0, 19) == 0);
      rrdy = ($urandom_range(0, 2) != 0);
      cycle(rrst, ra, rb, rfl, rrdy);
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
